// File: rtl/alu_seq_pkg.sv
// Shared constants for the 16-bit ALU sequencer: op codes, ALU mode/CAL codes,
// FSM state encoding and the per-beat ALU control lookup helpers.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_EQ   = 3'b101;
    localparam logic [2:0] OP_LTU  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam logic [1:0] MODE_ARITH = 2'b00;
    localparam logic [1:0] MODE_CMP   = 2'b01;
    localparam logic [1:0] MODE_PASS  = 2'b10;

    localparam logic [3:0] CAL_NONE = 4'b0000;
    localparam logic [3:0] CAL_ADD  = 4'b0000;
    localparam logic [3:0] CAL_SUB  = 4'b0001;
    localparam logic [3:0] CAL_ADC  = 4'b1001;
    localparam logic [3:0] CAL_SBB  = 4'b1010;
    localparam logic [3:0] CAL_AND  = 4'b0101;
    localparam logic [3:0] CAL_OR   = 4'b0110;
    localparam logic [3:0] CAL_XOR  = 4'b0111;
    localparam logic [3:0] CAL_EQ   = 4'b0000;
    localparam logic [3:0] CAL_LTU  = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // ALU mode used by every issued beat of an operation
    function automatic logic [1:0] beat_mode(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: beat_mode = MODE_ARITH;
            OP_EQ, OP_LTU:                         beat_mode = MODE_CMP;
            default:                               beat_mode = MODE_PASS;
        endcase
    endfunction

    // CAL for the low-byte beat
    function automatic logic [3:0] lo_cal(input logic [2:0] op);
        case (op)
            OP_ADD:  lo_cal = CAL_ADD;
            OP_SUB:  lo_cal = CAL_SUB;
            OP_AND:  lo_cal = CAL_AND;
            OP_OR:   lo_cal = CAL_OR;
            OP_XOR:  lo_cal = CAL_XOR;
            OP_EQ:   lo_cal = CAL_EQ;
            OP_LTU:  lo_cal = CAL_LTU;
            default: lo_cal = CAL_NONE;
        endcase
    endfunction

    // CAL for the high-byte beat: arithmetic ops switch to the carry-consuming form
    function automatic logic [3:0] hi_cal(input logic [2:0] op);
        case (op)
            OP_ADD:  hi_cal = CAL_ADC;
            OP_SUB:  hi_cal = CAL_SBB;
            default: hi_cal = lo_cal(op);
        endcase
    endfunction

endpackage

// File: rtl/alu_seq16_if.sv
// Request/response handshake bundle between issue logic and the ALU sequencer.
interface alu_seq16_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [2:0]  REQ_OP;
    logic [15:0] REQ_A;
    logic [15:0] REQ_B;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [15:0] RSP_DATA;
    logic        RSP_FLAG;
    logic        RSP_CARRY;
    logic        RSP_ERR;

    modport master (
        output REQ_VALID, REQ_OP, REQ_A, REQ_B, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_FLAG, RSP_CARRY, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_A, REQ_B, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_FLAG, RSP_CARRY, RSP_ERR
    );
endinterface

// File: rtl/alu_seq16.sv
// alu_seq16: breaks one 16-bit request into 2-3 byte beats on the shared 8-bit
// ALU, chains carry/borrow between beats and assembles a single response.
module alu_seq16
    import alu_seq_pkg::*;
(
    input  logic        CLK_EX,
    input  logic        RST_N,
    alu_seq16_if.slave  bus,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [3:0]  ALU_CAL,
    output logic [1:0]  ALU_MODE,
    output logic        ALU_C_IN,
    input  logic [7:0]  ALU_OUT,
    input  logic        ALU_C_OUT,
    input  logic        ALU_F_OUT
);

    state_e      state_q;
    state_e      state_d;
    logic [2:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  lo_byte_q;
    logic        lo_f_q;
    logic        hi_lt_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;
    logic        rsp_flag_q;
    logic        rsp_carry_q;
    logic        rsp_err_q;
    logic [15:0] rsp_data_d;
    logic        rsp_flag_d;
    logic        rsp_carry_d;
    logic        accept_s;

    assign accept_s      = (state_q == ST_IDLE) && bus.REQ_VALID;
    assign bus.REQ_READY = (state_q == ST_IDLE);
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_data_q;
    assign bus.RSP_FLAG  = rsp_flag_q;
    assign bus.RSP_CARRY = rsp_carry_q;
    assign bus.RSP_ERR   = rsp_err_q;

    // Next-state logic of the beat sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ_VALID) begin
                    if (bus.REQ_OP == OP_RSVD) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_B0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_B0:   state_d = ST_B1;
            ST_B1: begin
                if (op_q == OP_LTU) begin
                    state_d = ST_B2;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_B2:   state_d = ST_WAIT;
            ST_WAIT: state_d = ST_DONE;
            ST_DONE: begin
                if (bus.RSP_READY) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU drive per state; carry-in of the hi arithmetic beat is the lo-beat C_OUT directly
    always_comb begin
        ALU_MODE = MODE_PASS;
        ALU_CAL  = CAL_NONE;
        ALU_A    = 8'h00;
        ALU_B    = 8'h00;
        ALU_C_IN = 1'b0;
        case (state_q)
            ST_B0: begin
                ALU_A    = a_q[7:0];
                ALU_B    = b_q[7:0];
                ALU_MODE = beat_mode(op_q);
                ALU_CAL  = lo_cal(op_q);
            end
            ST_B1: begin
                ALU_A    = a_q[15:8];
                ALU_B    = b_q[15:8];
                ALU_MODE = beat_mode(op_q);
                ALU_CAL  = hi_cal(op_q);
                if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                    ALU_C_IN = ALU_C_OUT;
                end else begin
                    ALU_C_IN = 1'b0;
                end
            end
            ST_B2: begin
                ALU_A    = a_q[15:8];
                ALU_B    = b_q[15:8];
                ALU_MODE = MODE_CMP;
                ALU_CAL  = CAL_EQ;
            end
            default: begin
                ALU_MODE = MODE_PASS;
            end
        endcase
    end

    // Final response value, formed in WAIT from the last beat's ALU outputs
    always_comb begin
        rsp_data_d  = 16'h0000;
        rsp_flag_d  = 1'b0;
        rsp_carry_d = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                rsp_data_d  = {ALU_OUT, lo_byte_q};
                rsp_carry_d = ALU_C_OUT;
            end
            OP_AND, OP_OR, OP_XOR: rsp_data_d = {ALU_OUT, lo_byte_q};
            OP_EQ:   rsp_flag_d = lo_f_q & ALU_F_OUT;
            OP_LTU:  rsp_flag_d = hi_lt_q | (ALU_F_OUT & lo_f_q);
            default: rsp_data_d = 16'h0000;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK_EX or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, per-beat capture and response registers
    always_ff @(posedge CLK_EX or negedge RST_N) begin
        if (!RST_N) begin
            op_q        <= 3'b000;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            lo_byte_q   <= 8'h00;
            lo_f_q      <= 1'b0;
            hi_lt_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_flag_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_q        <= bus.REQ_OP;
                        a_q         <= bus.REQ_A;
                        b_q         <= bus.REQ_B;
                        rsp_data_q  <= 16'h0000;
                        rsp_flag_q  <= 1'b0;
                        rsp_carry_q <= 1'b0;
                        rsp_err_q   <= (bus.REQ_OP == OP_RSVD);
                        rsp_valid_q <= (bus.REQ_OP == OP_RSVD);
                    end
                end
                ST_B1: begin
                    lo_byte_q <= ALU_OUT;
                    lo_f_q    <= ALU_F_OUT;
                end
                ST_B2: begin
                    hi_lt_q <= ALU_F_OUT;
                end
                ST_WAIT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= rsp_data_d;
                    rsp_flag_q  <= rsp_flag_d;
                    rsp_carry_q <= rsp_carry_d;
                end
                ST_DONE: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= 16'h0000;
                        rsp_flag_q  <= 1'b0;
                        rsp_carry_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq16.md
# alu_seq16

16-bit operation sequencer for the 8-bit execute-stage ALU. It accepts one 16-bit request over a valid/ready handshake and breaks it into 2–3 byte beats on the ALU's input ports. Carry and borrow are chained between beats, and per-beat results and flags are collected into a single 16-bit response. It sits between the decode/issue logic and the ALU instance, and owns the ALU's operand, CAL, MODE and C_IN inputs.

## Interface
- No parameters; data width fixed at 16 bits, ALU byte width fixed at 8 bits.
- CLK_EX in 1: execute clock, shared with the ALU.
- RST_N in 1: asynchronous, active-low reset.
- REQ_VALID in 1: request valid.
- REQ_READY out 1: high only in IDLE.
- REQ_OP in 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 EQ, 110 LTU (unsigned less-than), 111 reserved.
- REQ_A, REQ_B in 16: operands.
- RSP_VALID out 1: response valid, held until accepted.
- RSP_READY in 1: response accept.
- RSP_DATA out 16: result; 0 for EQ, LTU and reserved.
- RSP_FLAG out 1: compare result; 0 for non-compare ops.
- RSP_CARRY out 1: high-byte C_OUT for ADD/SUB (SUB: 1 = borrow); 0 otherwise.
- RSP_ERR out 1: reserved op.
- ALU_A, ALU_B out 8: ALU operands.
- ALU_CAL out 4, ALU_MODE out 2, ALU_C_IN out 1: ALU controls.
- ALU_OUT in 8, ALU_C_OUT in 1, ALU_F_OUT in 1: ALU registered outputs.

## Operation
- ALU contract: inputs driven in cycle t are registered at the end of t, and outputs are valid throughout t+1. The ALU has no reset, so the sequencer ignores ALU outputs except in the cycle after an issued beat.
- Idle drive: ALU_MODE=10 (pass), ALU_CAL=0000, ALU_A=ALU_B=0, ALU_C_IN=0.
- Beat plan (MODE/CAL), low byte first unless noted:
  - ADD: 00/0000 lo, then 00/1001 hi with ALU_C_IN=ALU_C_OUT of the lo beat.
  - SUB: 00/0001 lo, then 00/1010 hi with ALU_C_IN=ALU_C_OUT of the lo beat (borrow).
  - AND/OR/XOR: 00/0101, 0110 or 0111 on lo then hi; ALU_C_IN=0.
  - EQ: 01/0000 lo then hi; RSP_FLAG = lo_f & hi_f.
  - LTU: 01/0010 lo, 01/0010 hi, 01/0000 hi; RSP_FLAG = hi_lt | (hi_eq & lo_lt).
  - Reserved: no beats issued; go straight to DONE with RSP_ERR=1 and all other response fields 0.
- FSM states: IDLE, B0, B1, B2, WAIT, DONE.
  - IDLE→B0 on REQ_VALID&REQ_READY: latch op and operands; for reserved op go IDLE→DONE.
  - B0→B1.
  - B1→B2 if LTU, else B1→WAIT.
  - B2→WAIT.
  - WAIT→DONE.
  - DONE→IDLE on RSP_READY.
- Capture: in the cycle after each beat issues, register ALU_OUT/ALU_F_OUT into the lo/hi result byte or flag slot. ALU_C_OUT is registered as RSP_CARRY only after the hi arithmetic beat.
- Response registers are cleared on acceptance in IDLE, so a stale RSP_DATA is never visible with RSP_VALID high.

## Timing
- Reset (asynchronous, any state): state=IDLE, REQ_READY=1, and RSP_*, ALU_* outputs at 0 except ALU_MODE=10. Any in-flight operation is discarded and no response is produced. Acceptance resumes on the first edge after RST_N deasserts.
- Latency from the acceptance edge to RSP_VALID: 4 cycles (2-beat ops), 5 cycles (LTU), 1 cycle (reserved).
- No overlap: REQ_READY=0 from acceptance until the DONE→IDLE edge. The minimum request spacing is 5 cycles (2-beat) or 6 cycles (LTU).
- Backpressure: while RSP_VALID=1 and RSP_READY=0, all RSP_* outputs are held stable and the ALU is driven to the idle values.
- If RSP_READY is already high on entry to DONE, the response is accepted at the next edge.
- Carry chaining: ALU_C_IN in the hi arithmetic beat is combinationally ALU_C_OUT, which is the registered lo-beat carry. No extra register stage is allowed.
- REQ_VALID asserted while REQ_READY=0 is ignored; the request is not latched.

## Structure
- Shared package alu_seq_pkg holds:
  - the op-code localparams (OP_ADD…OP_RSVD);
  - the ALU MODE values (MODE_ARITH=00, MODE_CMP=01, MODE_PASS=10);
  - the CAL values used here;
  - the state encoding.
- No internal sub-module: one FSM plus capture registers. The bench instantiates alu_seq16 wired to the existing ALU module on the same CLK_EX.

## Test plan
- ADD 0x12FF+0x0001 → RSP_DATA=0x1300, RSP_CARRY=0, RSP_VALID 4 cycles after accept. ADD 0xFFFF+0x0001 → 0x0000, RSP_CARRY=1.
- SUB 0x1000-0x0001 → 0x0FFF, RSP_CARRY=0. SUB 0x0000-0x0001 → 0xFFFF, RSP_CARRY=1.
- XOR 0xA5A5^0x0FF0 → 0xAA55. EQ 0xABCD vs 0xABCD → RSP_FLAG=1. EQ 0xABCD vs 0xABCC → RSP_FLAG=0.
- LTU 0x0100 vs 0x00FF → RSP_FLAG=0. LTU 0x00FE vs 0x00FF → RSP_FLAG=1. Both with latency 5.
- RSP_READY held low 3 cycles → RSP fields stable, REQ_READY=0, and a second REQ_VALID is not latched. Back-to-back requests complete in order.
- RST_N pulsed low during B1 of an ADD → all outputs at reset values, no RSP_VALID; next ADD is correct. OP=111 → RSP_ERR=1 one cycle after accept with no ALU beats issued (ALU_MODE stays 10).
